// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the register file's single write port between two producers:
//   port 0 : ALU result
//   port 1 : memory load
// Each producer owns a one-entry holding slot. One full slot is granted per
// cycle, and the granted entry is registered onto w_en/w_reg/w_data, which
// drive the register file's write port directly. The hazard outputs tell
// decode that a queried source register still has a write in flight.
//
// Build option (macro WB_ARB_ROUND_ROBIN_EN):
//   defined   : a both-full conflict on different registers is resolved
//               round-robin (the port not granted last wins).
//   undefined : the same conflict always goes to port 0, and no pointer
//               register exists.
//   If both slots target the same register, the older entry wins in either
//   build, so writes to one register always commit in arrival order.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   p0_valid/p0_ready     port 0 handshake
//   p0_reg, p0_data       port 0 destination register and value
//   p1_valid/p1_ready     port 1 handshake
//   p1_reg, p1_data       port 1 destination register and value
//   q_reg1, q_reg2        source registers queried by decode
//   hazard1, hazard2      a pending write targets q_reg1 / q_reg2
//   w_en, w_reg, w_data   registered write port to the register file
//   busy                  any slot full, or w_en high
//
// Handshake (both ports):
//   A transfer happens on a rising edge where valid && ready are both high.
//   ready = !full || granted. It depends only on slot state, never on
//   valid, and it is forced low while rst_n is low. A producer that sees
//   ready low must keep valid, reg and data stable. The arbiter never drops
//   an accepted entry except on reset.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH        = 8,
  parameter int REGISTER_ID_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,

  input  logic                         p0_valid,
  output logic                         p0_ready,
  input  logic [REGISTER_ID_WIDTH-1:0] p0_reg,
  input  logic [DATA_WIDTH-1:0]        p0_data,

  input  logic                         p1_valid,
  output logic                         p1_ready,
  input  logic [REGISTER_ID_WIDTH-1:0] p1_reg,
  input  logic [DATA_WIDTH-1:0]        p1_data,

  input  logic [REGISTER_ID_WIDTH-1:0] q_reg1,
  input  logic [REGISTER_ID_WIDTH-1:0] q_reg2,
  output logic                         hazard1,
  output logic                         hazard2,

  output logic                         w_en,
  output logic [REGISTER_ID_WIDTH-1:0] w_reg,
  output logic [DATA_WIDTH-1:0]        w_data,
  output logic                         busy
);

  // -------------------------------------------------------------------------
  // Holding slots
  // -------------------------------------------------------------------------
  logic                         full0;
  logic                         full1;
  logic [REGISTER_ID_WIDTH-1:0] slot0_reg;
  logic [REGISTER_ID_WIDTH-1:0] slot1_reg;
  logic [DATA_WIDTH-1:0]        slot0_data;
  logic [DATA_WIDTH-1:0]        slot1_data;

  // older == 0 : slot 0 holds the older entry
  // older == 1 : slot 1 holds the older entry
  // This bit only matters while both slots are full.
  logic older;

  logic grant0;
  logic grant1;
  logic acc0;
  logic acc1;

`ifdef WB_ARB_ROUND_ROBIN_EN
  // Port favoured on the next different-register conflict.
  // 0 = port 0, 1 = port 1. Each grant points it at the other port.
  logic rr_next;
`endif

  // -------------------------------------------------------------------------
  // Arbitration (combinational, slot state only)
  // -------------------------------------------------------------------------
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (full0 && !full1) begin
      grant0 = 1'b1;
    end else if (full1 && !full0) begin
      grant1 = 1'b1;
    end else if (full0 && full1) begin
      if (slot0_reg == slot1_reg) begin
        // Same destination: commit in arrival order.
        if (older) grant1 = 1'b1;
        else       grant0 = 1'b1;
      end else begin
`ifdef WB_ARB_ROUND_ROBIN_EN
        if (rr_next) grant1 = 1'b1;
        else         grant0 = 1'b1;
`else
        grant0 = 1'b1;
`endif
      end
    end
  end

  // A granted slot drains at the coming edge, so it can accept a new entry
  // on that same edge. rst_n gates ready so nothing is accepted in reset.
  assign p0_ready = rst_n && (!full0 || grant0);
  assign p1_ready = rst_n && (!full1 || grant1);

  assign acc0 = p0_valid && p0_ready;
  assign acc1 = p1_valid && p1_ready;

  // -------------------------------------------------------------------------
  // Slot registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full0      <= 1'b0;
      slot0_reg  <= '0;
      slot0_data <= '0;
    end else if (acc0) begin
      // The accept takes priority over the clear on a simultaneous grant:
      // the outgoing entry is captured by the output stage this same edge.
      full0      <= 1'b1;
      slot0_reg  <= p0_reg;
      slot0_data <= p0_data;
    end else if (grant0) begin
      full0 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full1      <= 1'b0;
      slot1_reg  <= '0;
      slot1_data <= '0;
    end else if (acc1) begin
      full1      <= 1'b1;
      slot1_reg  <= p1_reg;
      slot1_data <= p1_data;
    end else if (grant1) begin
      full1 <= 1'b0;
    end
  end

  // Arrival order. A lone new entry is younger than whatever the other slot
  // holds; if the other slot is or becomes empty the value is a don't-care
  // until that slot refills, which rewrites it. A tie goes to port 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      older <= 1'b0;
    end else if (acc0 && acc1) begin
      older <= 1'b0;
    end else if (acc0) begin
      older <= 1'b1;
    end else if (acc1) begin
      older <= 1'b0;
    end
  end

`ifdef WB_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_next <= 1'b0;
    end else if (grant0) begin
      rr_next <= 1'b1;
    end else if (grant1) begin
      rr_next <= 1'b0;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Output stage: registered write port
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_en   <= 1'b0;
      w_reg  <= '0;
      w_data <= '0;
    end else begin
      w_en <= grant0 || grant1;
      // With no grant, index and data keep their previous values.
      if (grant0) begin
        w_reg  <= slot0_reg;
        w_data <= slot0_data;
      end else if (grant1) begin
        w_reg  <= slot1_reg;
        w_data <= slot1_data;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Hazards and status
  // -------------------------------------------------------------------------
  // A write stays in flight until the register file commits it, i.e. until
  // the edge that ends the w_en cycle.
  always_comb begin
    hazard1 = (full0 && (slot0_reg == q_reg1)) ||
              (full1 && (slot1_reg == q_reg1)) ||
              (w_en  && (w_reg     == q_reg1));
    hazard2 = (full0 && (slot0_reg == q_reg2)) ||
              (full1 && (slot1_reg == q_reg2)) ||
              (w_en  && (w_reg     == q_reg2));
  end

  assign busy = full0 || full1 || w_en;

endmodule
